frame_scan_reader: RTL

- Read-side master for the data memory's second (read-only) port.
- Sweeps the frame buffer region of main memory in raster order, one word per active pixel, to drive a VGA-style display.
- Converts the 16-bit sign-extended lane value to an 8-bit clamped grey level.
- Generates hsync/vsync/blank timing with the pixel delayed to match memory read latency.

---
 rtl/frame_scan_reader.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/frame_scan_reader.sv
// rtl/frame_scan_reader.sv - raster frame-buffer read master with VGA timing and grey clamp
// Build option SCALE2X_EN: each image word covers a 2x2 block of screen pixels.
module frame_scan_reader #(
  parameter int H_ACTIVE  = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_ACTIVE  = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int IMG_W     = 256,
  parameter int IMG_H     = 256,
  parameter int BASE_ADDR = 0,
  parameter int CLK_DIV   = 2,
  parameter int RD_LAT    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  output logic [19:0] address2,
  input  logic [15:0] qb,
  output logic [7:0]  pixel,
  output logic        hsync,
  output logic        vsync,
  output logic        blank_n,
  output logic        frame_done
);

  localparam int H_TOT  = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOT  = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int HW     = $clog2(H_TOT);
  localparam int VW     = $clog2(V_TOT);
  localparam int DW     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int HS_ON  = H_ACTIVE + H_FP;
  localparam int HS_OFF = HS_ON + H_SYNC;
  localparam int VS_ON  = V_ACTIVE + V_FP;
  localparam int VS_OFF = VS_ON + V_SYNC;
`ifdef SCALE2X_EN
  localparam int SCALE  = 2;
`else
  localparam int SCALE  = 1;
`endif
  localparam int WIN_W  = IMG_W * SCALE;
  localparam int WIN_H  = IMG_H * SCALE;

  localparam logic [HW-1:0] H_LAST   = HW'(H_TOT - 1);
  localparam logic [VW-1:0] V_LAST   = VW'(V_TOT - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [19:0]   BASE     = 20'(BASE_ADDR);

  typedef enum logic {IDLE, SCAN} state_t;

  typedef struct packed {
    logic fdone;
    logic in_img;
    logic vis;
    logic vs;
    logic hs;
  } flags_t;

  localparam flags_t FLAGS_RST = '{fdone: 1'b0, in_img: 1'b0, vis: 1'b0, vs: 1'b1, hs: 1'b1};

  state_t        state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [HW-1:0] h_q, h_d;
  logic [VW-1:0] v_q, v_d;
  logic [19:0]   addr_q, addr_d;
  logic [7:0]    pixel_q, pixel_d;
`ifdef SCALE2X_EN
  logic [19:0]   line_start_q, line_start_d;
`endif
  flags_t        pipe_q [RD_LAT];
  flags_t        pipe_d [RD_LAT];
  flags_t        tap    [RD_LAT+1];
  flags_t        cur_flags;
  flags_t        conv_flags;

  logic pix_en;
  logic h_last;
  logic v_last;
  logic frame_start;
  logic scan_act;
  logic visible;
  logic in_img;

  // A frame's scan/idle decision is taken on the first clk of pixel (0,0)
  // and applies combinationally to that pixel, so no pixel is lost.
  always_comb begin
    state_d     = state_q;
    frame_start = (h_q == '0) && (v_q == '0) && (div_q == '0);
    scan_act    = (state_q == SCAN);
    if (frame_start) begin
      state_d  = enable ? SCAN : IDLE;
      scan_act = enable;
    end
  end

  always_comb begin
    pix_en  = (div_q == DIV_LAST);
    h_last  = (h_q == H_LAST);
    v_last  = (v_q == V_LAST);
    visible = (32'(h_q) < H_ACTIVE) && (32'(v_q) < V_ACTIVE);
    in_img  = (32'(h_q) < WIN_W) && (32'(v_q) < WIN_H) && scan_act;

    div_d = pix_en ? '0 : div_q + 1'b1;
    h_d   = h_q;
    v_d   = v_q;
    if (pix_en) begin
      h_d = h_last ? '0 : h_q + 1'b1;
      if (h_last) begin
        v_d = v_last ? '0 : v_q + 1'b1;
      end
    end

    addr_d = addr_q;
`ifdef SCALE2X_EN
    line_start_d = line_start_q;
    if (in_img && (h_q == '0)) begin
      line_start_d = addr_q;
    end
`endif
    // Rewind at the last pixel of the frame so (0,0) already sees BASE.
    if (pix_en && h_last && v_last) begin
      addr_d = BASE;
    end else if (pix_en && in_img) begin
`ifdef SCALE2X_EN
      if ((32'(h_q) == WIN_W - 1) && !v_q[0]) begin
        addr_d = line_start_q;
      end else if (h_q[0]) begin
        addr_d = addr_q + 20'd1;
      end
`else
      addr_d = addr_q + 20'd1;
`endif
    end

    cur_flags.hs     = !((32'(h_q) >= HS_ON) && (32'(h_q) < HS_OFF));
    cur_flags.vs     = !((32'(v_q) >= VS_ON) && (32'(v_q) < VS_OFF));
    cur_flags.vis    = visible && scan_act;
    cur_flags.in_img = in_img;
    cur_flags.fdone  = pix_en && (32'(h_q) == H_ACTIVE - 1) && (32'(v_q) == V_ACTIVE - 1);

    tap[0] = cur_flags;
    for (int k = 0; k < RD_LAT; k++) begin
      tap[k+1]  = pipe_q[k];
      pipe_d[k] = tap[k];
    end

    // qb for a given address arrives alongside the flags one stage before the output.
    conv_flags = tap[RD_LAT-1];
    pixel_d    = 8'h00;
    if (conv_flags.vis && conv_flags.in_img) begin
      if (qb[15]) begin
        pixel_d = 8'h00;
      end else if (|qb[14:8]) begin
        pixel_d = 8'hFF;
      end else begin
        pixel_d = qb[7:0];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      div_q   <= '0;
      h_q     <= '0;
      v_q     <= '0;
      addr_q  <= BASE;
      pixel_q <= '0;
`ifdef SCALE2X_EN
      line_start_q <= BASE;
`endif
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_q[k] <= FLAGS_RST;
      end
    end else begin
      div_q   <= div_d;
      h_q     <= h_d;
      v_q     <= v_d;
      addr_q  <= addr_d;
      pixel_q <= pixel_d;
`ifdef SCALE2X_EN
      line_start_q <= line_start_d;
`endif
      for (int k = 0; k < RD_LAT; k++) begin
        pipe_q[k] <= pipe_d[k];
      end
    end
  end

  assign address2   = addr_q;
  assign pixel      = pixel_q;
  assign hsync      = pipe_q[RD_LAT-1].hs;
  assign vsync      = pipe_q[RD_LAT-1].vs;
  assign blank_n    = pipe_q[RD_LAT-1].vis;
  assign frame_done = pipe_q[RD_LAT-1].fdone;

endmodule
